// File: rtl/truth_table_sweeper.sv
// Sweeps a 4-input function block through all input vectors, captures F, compares to an expected mask.
// Optional SWEEP_HALT_ON_FAIL_EN: stop the sweep at the first mismatching vector.
module truth_table_sweeper #(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [(2**N_IN)-1:0]   expect_mask_i,
    output logic [N_IN-1:0]        vec_out_o,
    input  logic                   f_in_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [(2**N_IN)-1:0]   table_out_o,
    output logic [N_IN:0]          mismatch_count_o,
    output logic [N_IN-1:0]        first_fail_idx_o
);

    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   settle_q, settle_d;
    logic [NV-1:0]   mask_q, mask_d;
    logic [NV-1:0]   table_q, table_d;
    logic [N_IN:0]   count_q, count_d;
    logic [N_IN-1:0] ffi_q, ffi_d;
    logic            pass_q, pass_d;

    logic mismatch;
    logic last_vec;

    assign mismatch = (f_in_i != mask_q[idx_q]);
    assign last_vec = (idx_q == {N_IN{1'b1}});

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        mask_d   = mask_q;
        table_d  = table_q;
        count_d  = count_q;
        ffi_d    = ffi_q;
        pass_d   = pass_q;

        // Abort wins over every other transition; partial results stay as they are.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        mask_d  = expect_mask_i;
                        table_d = '0;
                        count_d = '0;
                        ffi_d   = '0;
                        pass_d  = 1'b0;
                        idx_d   = '0;
                        state_d = ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    settle_d = CW'(SETTLE_CYCLES);
                    state_d  = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (settle_q <= CW'(1)) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q - CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    table_d[idx_q] = f_in_i;
                    if (mismatch) begin
                        count_d = count_q + (N_IN+1)'(1);
                        if (count_q == '0) begin
                            ffi_d = idx_q;
                        end
                    end
`ifdef SWEEP_HALT_ON_FAIL_EN
                    if (mismatch) begin
                        state_d = ST_DONE;
                        pass_d  = 1'b0;
                    end else if (last_vec) begin
                        state_d = ST_DONE;
                        pass_d  = (count_q == '0);
                    end else begin
                        idx_d   = idx_q + N_IN'(1);
                        state_d = ST_APPLY;
                    end
`else
                    if (last_vec) begin
                        state_d = ST_DONE;
                        pass_d  = !mismatch && (count_q == '0);
                    end else begin
                        idx_d   = idx_q + N_IN'(1);
                        state_d = ST_APPLY;
                    end
`endif
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            mask_q   <= '0;
            table_q  <= '0;
            count_q  <= '0;
            ffi_q    <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            mask_q   <= mask_d;
            table_q  <= table_d;
            count_q  <= count_d;
            ffi_q    <= ffi_d;
            pass_q   <= pass_d;
        end
    end

    assign vec_out_o        = idx_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = (state_q == ST_DONE);
    assign pass_o           = pass_q;
    assign table_out_o      = table_q;
    assign mismatch_count_o = count_q;
    assign first_fail_idx_o = ffi_q;

endmodule
